// File: rtl/vga_pkg.sv
// Shared definitions for the VGA video engine.
//   mode_t       : test-pattern selector values (MODE_SOLID..MODE_BOX)
//   VGA_*        : 640x480@60 timing constants, used as parameter defaults
//   bar_rgb()    : colour-bar table, one on/off bit per channel {r,g,b}
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    localparam int unsigned VGA_H_ACT  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_V_ACT  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern source for the VGA engine. Colour is combinational from the
// current counter position; the top registers it with the sync signals.
//   clk, rst_n_a      : system clock, asynchronous active-low reset
//   x, y              : current h/v counter values
//   active            : position is inside the visible region
//   mode_q            : pattern for the current frame
//   pe                : pixel enable
//   red, green, blue  : raw colour, zero outside the active region
// Owns the bouncing-box position/direction, which steps once per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT   = VGA_H_ACT,
    parameter int unsigned V_ACT   = VGA_V_ACT,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned CW      = 4,
    parameter int unsigned BOX     = 32,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 10
) (
    input  logic          clk,
    input  logic          rst_n_a,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          active,
    input  mode_t         mode_q,
    input  logic          pe,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int unsigned   BAR_W  = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
    localparam logic [XW-1:0] BX_MAX = XW'(H_ACT - BOX);
    localparam logic [YW-1:0] BY_MAX = YW'(V_ACT - BOX);

    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic          dx_neg;
    logic          dy_neg;
    logic          frame_end;

    assign frame_end = pe && (x == XW'(H_TOTAL - 1)) && (y == YW'(V_TOTAL - 1));

    // At a limit the direction flips and the same frame's step goes the other way,
    // so the box sits on the limit for exactly one frame.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            bx     <= '0;
            by     <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (frame_end) begin
            if (!dx_neg) begin
                if (bx == BX_MAX) begin
                    dx_neg <= 1'b1;
                    bx     <= bx - XW'(1);
                end else begin
                    bx <= bx + XW'(1);
                end
            end else begin
                if (bx == '0) begin
                    dx_neg <= 1'b0;
                    bx     <= bx + XW'(1);
                end else begin
                    bx <= bx - XW'(1);
                end
            end
            if (!dy_neg) begin
                if (by == BY_MAX) begin
                    dy_neg <= 1'b1;
                    by     <= by - YW'(1);
                end else begin
                    by <= by + YW'(1);
                end
            end else begin
                if (by == '0) begin
                    dy_neg <= 1'b0;
                    by     <= by + YW'(1);
                end else begin
                    by <= by - YW'(1);
                end
            end
        end
    end

    logic [31:0] bar_n;
    logic [2:0]  bar_idx;
    logic        in_box;
    logic [2:0]  rgb_on;

    always_comb begin
        bar_n   = 32'(x) / BAR_W;
        // Last bar absorbs any remainder of H_ACT/8.
        bar_idx = (bar_n > 32'd7) ? 3'd7 : bar_n[2:0];
        in_box  = (x >= bx) && (x < bx + XW'(BOX)) && (y >= by) && (y < by + YW'(BOX));
        rgb_on  = '0;
        case (mode_q)
            MODE_SOLID: rgb_on = 3'b111;
            MODE_BARS:  rgb_on = bar_rgb(bar_idx);
            MODE_CHECK: rgb_on = {3{((32'(x) ^ 32'(y)) & 32'd32) != 32'd0}};
            MODE_BOX:   rgb_on = {3{in_box}};
            default:    rgb_on = '0;
        endcase
        if (!active) begin
            rgb_on = '0;
        end
        red   = {CW{rgb_on[2]}};
        green = {CW{rgb_on[1]}};
        blue  = {CW{rgb_on[0]}};
    end

endmodule

// File: rtl/vga_video_core.sv
// Parametrised VGA video engine: pixel-enable divider, H/V counters,
// sync/DE decode, test-pattern source and registered output stage.
//   clk, rst_n_a      : system clock, asynchronous active-low reset
//   mode              : 0 solid white, 1 colour bars, 2 checker, 3 bouncing box
//   hsync, vsync      : syncs, asserted level HS_POL / VS_POL
//   red, green, blue  : pixel colour, zero in blanking
//   de                : display enable
//   pix_x, pix_y      : position of the pixel currently on the outputs
//   frame_start       : one-clock pulse when (0,0) reaches the outputs
// All pins update on pixel enable, one tick after the counters.
module vga_video_core
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_ACT   = VGA_H_ACT,
    parameter int unsigned H_FP    = VGA_H_FP,
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BP    = VGA_H_BP,
    parameter int unsigned V_ACT   = VGA_V_ACT,
    parameter int unsigned V_FP    = VGA_V_FP,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BP    = VGA_V_BP,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned CW      = 4,
    parameter int unsigned BOX     = 32,
    localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n_a,
    input  logic [1:0]    mode,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          de,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          frame_start
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          pe;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          origin;
    logic          active;
    logic          in_hs;
    logic          in_vs;
    mode_t         mode_q;
    mode_t         mode_sel;
    logic [CW-1:0] pat_r;
    logic [CW-1:0] pat_g;
    logic [CW-1:0] pat_b;

    assign pe = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign origin = (h_cnt == '0) && (v_cnt == '0);
    assign active = (h_cnt < HW'(H_ACT)) && (v_cnt < VW'(V_ACT));
    assign in_hs  = (h_cnt >= HW'(H_ACT + H_FP)) && (h_cnt < HW'(H_ACT + H_FP + H_SYNC));
    assign in_vs  = (v_cnt >= VW'(V_ACT + V_FP)) && (v_cnt < VW'(V_ACT + V_FP + V_SYNC));

    // The mode sampled at (0,0) is forwarded straight to the pattern source so the
    // origin pixel already uses the new frame's mode.
    always_comb begin
        mode_sel = mode_q;
        if (origin) begin
            mode_sel = mode_t'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            mode_q <= MODE_SOLID;
        end else if (pe && origin) begin
            mode_q <= mode_sel;
        end
    end

    vga_pattern_gen #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CW      (CW),
        .BOX     (BOX),
        .XW      (HW),
        .YW      (VW)
    ) u_pattern (
        .clk     (clk),
        .rst_n_a (rst_n_a),
        .x       (h_cnt),
        .y       (v_cnt),
        .active  (active),
        .mode_q  (mode_sel),
        .pe      (pe),
        .red     (pat_r),
        .green   (pat_g),
        .blue    (pat_b)
    );

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            red   <= '0;
            green <= '0;
            blue  <= '0;
            de    <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
        end else if (pe) begin
            hsync <= in_hs ? HS_POL : ~HS_POL;
            vsync <= in_vs ? VS_POL : ~VS_POL;
            red   <= pat_r;
            green <= pat_g;
            blue  <= pat_b;
            de    <= active;
            pix_x <= h_cnt;
            pix_y <= v_cnt;
        end
    end

    // Strobed every clock so it stays one system clock wide for any CLK_DIV.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pe && origin;
        end
    end

endmodule
